// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct constants, decode enums and control struct for the MIPS decode stage
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } de_alu_op_t;

  typedef enum logic [2:0] {IMM_NONE, IMM_SEXT, IMM_LUI, IMM_SHAMT, IMM_LINK} imm_kind_t;

  typedef enum logic [2:0] {BR_NONE, BR_BEQ, BR_BNE, BR_J, BR_JR} br_type_t;

  // All-zero value of this struct is the NOP decode.
  typedef struct packed {
    de_alu_op_t alu_op;
    logic [4:0] dest;
    logic       use_rs;
    logic       use_rt;
    imm_kind_t  imm_kind;
    br_type_t   br_type;
    logic       mem_re;
    logic       mem_we;
  } dec_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_inst_decoder.sv
// rtl/mips_inst_decoder.sv - combinational instruction word to control-field decoder
module mips_inst_decoder
  import mips_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [9:0] unused_fields;

  assign opcode        = inst_i[31:26];
  assign funct         = inst_i[5:0];
  assign rt            = inst_i[20:16];
  assign rd            = inst_i[15:11];
  assign unused_fields = {inst_i[25:21], inst_i[10:6]};

  always_comb begin
    dec_o = '0;
    case (opcode)
      OP_SPECIAL: begin
        dec_o.dest   = rd;
        dec_o.use_rs = 1'b1;
        dec_o.use_rt = 1'b1;
        case (funct)
          FN_ADDU: dec_o.alu_op = ALU_ADD;
          FN_SUBU: dec_o.alu_op = ALU_SUB;
          FN_SLT:  dec_o.alu_op = ALU_SLT;
          FN_SLTU: dec_o.alu_op = ALU_SLTU;
          FN_AND:  dec_o.alu_op = ALU_AND;
          FN_OR:   dec_o.alu_op = ALU_OR;
          FN_XOR:  dec_o.alu_op = ALU_XOR;
          FN_NOR:  dec_o.alu_op = ALU_NOR;
          FN_SLL: begin
            dec_o.alu_op   = ALU_SLL;
            dec_o.use_rs   = 1'b0;
            dec_o.imm_kind = IMM_SHAMT;
          end
          FN_SRL: begin
            dec_o.alu_op   = ALU_SRL;
            dec_o.use_rs   = 1'b0;
            dec_o.imm_kind = IMM_SHAMT;
          end
          FN_SRA: begin
            dec_o.alu_op   = ALU_SRA;
            dec_o.use_rs   = 1'b0;
            dec_o.imm_kind = IMM_SHAMT;
          end
          FN_JR: begin
            dec_o.dest    = 5'd0;
            dec_o.use_rt  = 1'b0;
            dec_o.br_type = BR_JR;
          end
          default: dec_o = '0;
        endcase
      end
      OP_ADDIU: begin
        dec_o.dest     = rt;
        dec_o.use_rs   = 1'b1;
        dec_o.imm_kind = IMM_SEXT;
      end
      OP_LUI: begin
        dec_o.dest     = rt;
        dec_o.alu_op   = ALU_LUI;
        dec_o.imm_kind = IMM_LUI;
      end
      OP_LW: begin
        dec_o.dest     = rt;
        dec_o.use_rs   = 1'b1;
        dec_o.imm_kind = IMM_SEXT;
        dec_o.mem_re   = 1'b1;
      end
      OP_SW: begin
        dec_o.use_rs   = 1'b1;
        dec_o.use_rt   = 1'b1;
        dec_o.imm_kind = IMM_SEXT;
        dec_o.mem_we   = 1'b1;
      end
      OP_BEQ: begin
        dec_o.use_rs  = 1'b1;
        dec_o.use_rt  = 1'b1;
        dec_o.br_type = BR_BEQ;
      end
      OP_BNE: begin
        dec_o.use_rs  = 1'b1;
        dec_o.use_rt  = 1'b1;
        dec_o.br_type = BR_BNE;
      end
      OP_J: dec_o.br_type = BR_J;
      OP_JAL: begin
        dec_o.dest     = 5'd31;
        dec_o.imm_kind = IMM_LINK;
        dec_o.br_type  = BR_J;
      end
      default: dec_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_decode_stage.sv
// rtl/mips_decode_stage.sv - MIPS decode stage: pipeline register, hazards, operands, branches; DE_BYPASS_EN enables forwarding
module mips_decode_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] DE_PC_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fe_valid_ready_go,
  input  logic [31:0] fe_pc,
  input  logic [31:0] fe_instruction,
  output logic        de_allowin,
  output logic [31:0] pc_next,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        ex_allowin,
  input  logic        ex_valid,
  input  logic        mem_valid,
  input  logic        wb_valid,
  input  logic [4:0]  ex_dest,
  input  logic [4:0]  mem_dest,
  input  logic [4:0]  wb_dest,
  input  logic        ex_is_load,
  input  logic [31:0] ex_result,
  input  logic [31:0] mem_result,
  input  logic [31:0] wb_result,
  output logic        de_valid,
  output logic        de_valid_ready_go,
  output logic [31:0] de_pc,
  output de_alu_op_t  de_alu_op,
  output logic [31:0] de_src1,
  output logic [31:0] de_src2,
  output logic [31:0] de_store_data,
  output logic [4:0]  de_dest,
  output logic        de_mem_re,
  output logic        de_mem_we
);

  logic        de_valid_q, de_valid_d;
  logic [31:0] de_pc_q, de_pc_d;
  logic [31:0] de_inst_q, de_inst_d;

  dec_t        dec;
  logic [4:0]  rs, rt, shamt;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val;
  logic        rs_hazard, rt_hazard;
  logic        stall, de_ready_go;
  logic        br_taken;
  logic [31:0] br_target;

  always_comb begin
    de_valid_d = de_valid_q;
    de_pc_d    = de_pc_q;
    de_inst_d  = de_inst_q;
    if (de_allowin) begin
      de_valid_d = fe_valid_ready_go;
      if (fe_valid_ready_go) begin
        de_pc_d   = fe_pc;
        de_inst_d = fe_instruction;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_valid_q <= 1'b0;
      de_pc_q    <= DE_PC_RESET;
      de_inst_q  <= '0;
    end else begin
      de_valid_q <= de_valid_d;
      de_pc_q    <= de_pc_d;
      de_inst_q  <= de_inst_d;
    end
  end

  mips_inst_decoder u_dec (
    .inst_i (de_inst_q),
    .dec_o  (dec)
  );

  assign rs        = de_inst_q[25:21];
  assign rt        = de_inst_q[20:16];
  assign shamt     = de_inst_q[10:6];
  assign imm       = de_inst_q[15:0];
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

`ifdef DE_BYPASS_EN
  // Youngest producer wins; only a load still in execute has no value yet.
  always_comb begin
    rs_val = rf_rdata1;
    rt_val = rf_rdata2;
    if (rs != 5'd0) begin
      if (ex_valid && ex_dest == rs)        rs_val = ex_result;
      else if (mem_valid && mem_dest == rs) rs_val = mem_result;
      else if (wb_valid && wb_dest == rs)   rs_val = wb_result;
    end
    if (rt != 5'd0) begin
      if (ex_valid && ex_dest == rt)        rt_val = ex_result;
      else if (mem_valid && mem_dest == rt) rt_val = mem_result;
      else if (wb_valid && wb_dest == rt)   rt_val = wb_result;
    end
  end
  assign rs_hazard = ex_valid && ex_is_load && ex_dest == rs;
  assign rt_hazard = ex_valid && ex_is_load && ex_dest == rt;
`else
  logic [96:0] unused_fwd;
  assign unused_fwd = {ex_result, mem_result, wb_result, ex_is_load};
  assign rs_val     = rf_rdata1;
  assign rt_val     = rf_rdata2;
  assign rs_hazard  = (ex_valid && ex_dest == rs) || (mem_valid && mem_dest == rs) ||
                      (wb_valid && wb_dest == rs);
  assign rt_hazard  = (ex_valid && ex_dest == rt) || (mem_valid && mem_dest == rt) ||
                      (wb_valid && wb_dest == rt);
`endif

  assign stall = (dec.use_rs && rs != 5'd0 && rs_hazard) ||
                 (dec.use_rt && rt != 5'd0 && rt_hazard);
  assign de_ready_go       = !stall;
  assign de_valid_ready_go = de_valid_q && de_ready_go;
  assign de_allowin        = !rst && (!de_valid_q || (de_ready_go && ex_allowin));

  always_comb begin
    de_src1 = rs_val;
    de_src2 = rt_val;
    case (dec.imm_kind)
      IMM_SEXT:  de_src2 = sext16(imm);
      IMM_LUI:   de_src2 = {imm, 16'h0};
      IMM_SHAMT: de_src1 = {27'd0, shamt};
      IMM_LINK: begin
        de_src1 = de_pc_q;
        de_src2 = 32'd8;
      end
      default: ;
    endcase
  end

  always_comb begin
    br_taken  = 1'b0;
    br_target = de_pc_q + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    case (dec.br_type)
      BR_BEQ: br_taken = (rs_val == rt_val);
      BR_BNE: br_taken = (rs_val != rt_val);
      BR_J: begin
        br_taken  = 1'b1;
        br_target = {de_pc_q[31:28], de_inst_q[25:0], 2'b00};
      end
      BR_JR: begin
        br_taken  = 1'b1;
        br_target = rs_val;
      end
      default: ;
    endcase
  end

  // The instruction in fetch is the delay slot, so only the one after it is redirected.
  assign pc_next = (!rst && de_valid_ready_go && br_taken) ? br_target : fe_pc + 32'd4;

  assign de_valid      = de_valid_q;
  assign de_pc         = de_pc_q;
  assign de_alu_op     = dec.alu_op;
  assign de_store_data = rt_val;
  assign de_dest       = dec.dest;
  assign de_mem_re     = dec.mem_re;
  assign de_mem_we     = dec.mem_we;

endmodule

// File: doc/mips_decode_stage.md
# mips_decode_stage

Second stage of the five-stage MIPS pipeline. It accepts the fetch stage's PC and instruction word over the valid/allowin handshake and drives allowin back to fetch. It decodes the instruction, reads operands from the register file, and detects RAW hazards, stalling or forwarding as configured. It resolves branches and jumps, returning `pc_next` to fetch with one architectural delay slot, and presents decoded operands to the execute stage over the same handshake.

## Interface
Parameters:
- `DE_PC_RESET`, 32'h0, reset value of `de_pc`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  pipeline clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `fe_valid_ready_go`  in  1  fetch holds a valid instruction that is ready to hand over.
- `fe_pc`  in  32  PC of the instruction in fetch.
- `fe_instruction`  in  32  instruction word in fetch.
- `de_allowin`  out  1  decode accepts a new instruction this cycle.
- `pc_next`  out  32  next fetch PC; sampled by fetch only on its allowin.
- `rf_raddr1`, `rf_raddr2`  out  5  register file read addresses (rs, rt). Reads are combinational and not write-through.
- `rf_rdata1`, `rf_rdata2`  in  32  register file read data.
- `ex_allowin`  in  1  execute accepts an instruction.
- `ex_valid`, `mem_valid`, `wb_valid`  in  1  downstream stage occupancy.
- `ex_dest`, `mem_dest`, `wb_dest`  in  5  destination register per stage; 0 means none.
- `ex_is_load`  in  1  instruction in execute is LW.
- `ex_result`, `mem_result`, `wb_result`  in  32  forwarding data. Used only with `DE_BYPASS_EN`.
- `de_valid`  out  1  decode holds an instruction.
- `de_valid_ready_go`  out  1  instruction may move to execute.
- `de_pc`  out  32  PC of the decoded instruction.
- `de_alu_op`  out  4  ALU operation code (package enum).
- `de_src1`, `de_src2`  out  32  ALU operands after immediate and shamt selection.
- `de_store_data`  out  32  rt value for SW.
- `de_dest`  out  5  destination register; 0 for no write.
- `de_mem_re`, `de_mem_we`  out  1  load/store flags.

## Operation
- Supported: ADDU SUBU SLT SLTU AND OR XOR NOR SLL SRL SRA ADDIU LUI LW SW BEQ BNE J JAL JR. Any other encoding decodes as NOP: dest 0, no memory access, not a branch.
- Pipeline register holds `de_valid`, `de_pc`, `de_inst`.
  - On `de_allowin`: `de_valid <= fe_valid_ready_go`.
  - `de_pc` and `de_inst` load only when `fe_valid_ready_go` is 1.
- `de_allowin = !rst && (!de_valid || (de_ready_go && ex_allowin))`.
- `de_valid_ready_go = de_valid && de_ready_go`.
- `de_ready_go = !stall`.
- Source use: rs is used by R-type ALU ops (except shifts), ADDIU, LW, SW, BEQ, BNE, JR. rt is used by R-type ALU ops, shifts, SW, BEQ, BNE. Register 0 never creates a hazard.
- Immediates:
  - ADDIU, LW, SW: sign-extended.
  - LUI: `{imm,16'h0}`.
  - Shifts: src1 = zero-extended shamt, src2 = rt.
- JAL: dest 31, src1 = `de_pc`, src2 = 8. Execute computes `de_pc + 8`.
- Branch/jump targets:
  - BEQ, BNE: `de_pc + 4 + (sext(imm) << 2)`.
  - J, JAL: `{de_pc[31:28], index, 2'b00}`.
  - JR: rs value.
- `pc_next` is the target when `de_valid_ready_go` and taken; otherwise `fe_pc + 4`. The instruction in fetch is the delay slot and is always executed.

## Timing
- Reset: `de_valid=0`, `de_pc=DE_PC_RESET`, `de_inst=0`.
  - All decoded outputs then equal the NOP decode: dest 0, `mem_re=0`, `mem_we=0`.
  - `de_allowin=0` while `rst`.
- Latency: one cycle from fetch handoff to `de_valid`. Decode outputs are combinational from the pipeline register.
- A taken branch redirects fetch on the same edge that moves the branch to execute and the delay slot into decode.
- Branch compare uses post-forwarding operands. A stalled branch holds `pc_next` at `fe_pc+4`, but fetch is also stalled, so that value is not consumed.
- Reset mid-operation: the in-flight instruction is dropped; no `pc_next` redirect is honoured after reset.
- Simultaneous fetch handoff and downstream stall: decode holds its instruction, and fetch keeps its own.

## Configuration
- `DE_BYPASS_EN` defined:
  - Operands are forwarded with priority ex > mem > wb > register file.
  - Stall only when `ex_valid && ex_is_load` and `ex_dest` matches a used source (1-cycle load-use bubble).
- `DE_BYPASS_EN` undefined:
  - Stall while any valid ex/mem/wb dest matches a used nonzero source.
  - `*_result` ports are ignored.

## Structure
- Package `mips_pkg`:
  - opcode/funct localparams;
  - `de_alu_op` enum (ADD SUB SLT SLTU AND OR XOR NOR SLL SRL SRA LUI);
  - reset PC constant `32'hbfc00000`.
- Sub-module `mips_inst_decoder`: combinational. Maps the instruction word to alu_op, dest, source-use flags, immediate kind, and branch type.
- Hazard, forwarding, and target logic live in `mips_decode_stage`.

## Test plan
- Reset, then handoff of ADDU r3,r1,r2 (r1=5, r2=7) at pc 0xbfc00000:
  - next cycle `de_valid=1`, `de_src1=5`, `de_src2=7`, `de_dest=3`.
- `ex_allowin=0` for 3 cycles with a valid instruction in decode: `de_allowin=0` and the outputs hold; instruction leaves on the first cycle `ex_allowin=1`.
- BEQ r1,r1,+4 at 0x100:
  - `pc_next=0x114` on the handoff edge;
  - the delay slot at 0x104 enters decode.
- LW r2 in ex, then ADDU r4,r2,r2:
  - bypass: 1 stall cycle, then src1 = src2 = `mem_result`;
  - no bypass: stall until wb clears.
- ADDU r5 in mem (`mem_result=0x55`) and ADDU r5 in ex (`ex_result=0xAA`), consumer reads r5:
  - bypass: `de_src1=0xAA`.
- Undefined opcode 0x3F: `de_dest=0`, `de_mem_we=0`, no stall; JAL at 0x200 gives `de_dest=31`, `de_src1=0x200`, `de_src2=8`.
